// File: rtl/output_layer_accum.sv
`default_nettype none
// ============================================================================
// Module  : output_layer_accum
// Brief   : Final MNIST dense layer: 10 parallel MACs over a stream of hidden
//           activations, plus bias, rescale and saturate, with a valid/ready
//           handshake to the argmax stage.
// Revision: 1.0 - initial release
// ============================================================================
module output_layer_accum #(
    parameter int W     = 16,
    parameter int FRAC  = 8,
    parameter int N_IN  = 32,
    parameter int N_OUT = 10,
    parameter int ACC_W = 40
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_OUT*W-1:0] bias,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_act,
    input  logic [N_OUT*W-1:0] in_w,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N_OUT*W-1:0] scores,
    output logic               busy
);

    localparam int CNT_W = $clog2(N_IN + 1);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(N_IN - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_accum = 2'd1;
    localparam logic [1:0] c_st_sat   = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    // Clamp limits of the W-bit score format, expressed at accumulator width.
    localparam logic signed [ACC_W-1:0] c_sat_max = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_sat_min = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

    logic [1:0]               r_state;
    logic [CNT_W-1:0]         r_count;
    logic signed [ACC_W-1:0]  r_acc [N_OUT];
    logic [N_OUT*W-1:0]       r_scores;

    logic signed [ACC_W-1:0]  w_prod_ext [N_OUT];
    logic signed [ACC_W-1:0]  w_bias_ext [N_OUT];
    logic [N_OUT*W-1:0]       w_sat_bus;

    for (genvar k = 0; k < N_OUT; k++) begin : g_class
        logic signed [2*W-1:0]   w_x;
        logic signed [2*W-1:0]   w_wk;
        logic signed [2*W-1:0]   w_prod;
        logic signed [W-1:0]     w_b;
        logic signed [ACC_W-1:0] w_t;

        assign w_x    = {{W{in_act[W-1]}}, in_act};
        assign w_wk   = {{W{in_w[k*W+W-1]}}, in_w[k*W +: W]};
        assign w_prod = w_x * w_wk;
        assign w_prod_ext[k] = {{(ACC_W-2*W){w_prod[2*W-1]}}, w_prod};

        assign w_b = bias[k*W +: W];
        assign w_bias_ext[k] = {{(ACC_W-W){w_b[W-1]}}, w_b} <<< FRAC;

        // Arithmetic shift floors toward -inf before clamping to the W-bit range.
        assign w_t = r_acc[k] >>> FRAC;
        assign w_sat_bus[k*W +: W] = (w_t > c_sat_max) ? c_sat_max[W-1:0] :
                                     (w_t < c_sat_min) ? c_sat_min[W-1:0] :
                                                         w_t[W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_count  <= '0;
            r_scores <= '0;
            for (int k = 0; k < N_OUT; k++) r_acc[k] <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        for (int k = 0; k < N_OUT; k++) r_acc[k] <= w_bias_ext[k];
                        r_count <= '0;
                        r_state <= c_st_accum;
                    end
                end
                c_st_accum: begin
                    if (in_valid) begin
                        for (int k = 0; k < N_OUT; k++) r_acc[k] <= r_acc[k] + w_prod_ext[k];
                        r_count <= r_count + CNT_W'(1);
                        if (r_count == c_last) r_state <= c_st_sat;
                    end
                end
                c_st_sat: begin
                    r_scores <= w_sat_bus;
                    r_state  <= c_st_done;
                end
                c_st_done: begin
                    if (out_ready) r_state <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign in_ready  = (r_state == c_st_accum);
    assign out_valid = (r_state == c_st_done);
    assign busy      = (r_state != c_st_idle);
    assign scores    = r_scores;

endmodule
`default_nettype wire

// File: tb/tb_output_layer_accum.sv
`default_nettype none
// ============================================================================
// Module  : tb_output_layer_accum
// Brief   : Directed scoreboard bench for output_layer_accum (N_IN=4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_output_layer_accum;

    localparam int W     = 16;
    localparam int FRAC  = 8;
    localparam int N_IN  = 4;
    localparam int N_OUT = 10;
    localparam int ACC_W = 40;
    localparam int BW    = N_OUT * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [BW-1:0] bias;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_act;
    logic [BW-1:0] in_w;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] scores;
    logic          busy;

    output_layer_accum #(.W(W), .FRAC(FRAC), .N_IN(N_IN), .N_OUT(N_OUT), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_w(in_w),
        .out_valid(out_valid), .out_ready(out_ready), .scores(scores), .busy(busy)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    longint        macc [N_OUT];
    logic [BW-1:0] sb_q [$];

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] model_scores();
        logic [BW-1:0] bus;
        longint t;
        bus = '0;
        for (int k = 0; k < N_OUT; k++) begin
            t = macc[k] >>> FRAC;
            if (t > 32767) t = 32767;
            if (t < -32768) t = -32768;
            bus[k*W +: W] = t[W-1:0];
        end
        return bus;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [BW-1:0] b);
        start = 1'b1;
        bias  = b;
        for (int k = 0; k < N_OUT; k++) macc[k] = longint'($signed(b[k*W +: W])) * 256;
        tick();
        start = 1'b0;
        check("start_busy", BW'(busy), BW'(1));
        check("start_in_ready", BW'(in_ready), BW'(1));
    endtask

    task automatic send_beat(input logic [W-1:0] x, input logic [BW-1:0] wb, input int gap);
        logic rdy;
        int   n;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            tick();
        end
        in_valid = 1'b1;
        in_act   = x;
        in_w     = wb;
        n = 0;
        do begin
            rdy = in_ready;
            tick();
            n++;
        end while (!rdy && n < 20);
        in_valid = 1'b0;
        in_act   = $urandom();
        in_w     = {5{$urandom()}};
        if (!rdy) check("beat_accept_timeout", BW'(rdy), BW'(1));
        for (int k = 0; k < N_OUT; k++)
            macc[k] += longint'($signed(x)) * longint'($signed(wb[k*W +: W]));
    endtask

    // Last beat has just been accepted: push the expectation and check the latency.
    task automatic finish_beats();
        sb_q.push_back(model_scores());
        check("lat_sat_no_valid", BW'(out_valid), BW'(0));
        tick();
        check("lat_done_valid", BW'(out_valid), BW'(1));
    endtask

    task automatic drain(input int hold);
        logic [BW-1:0] exp;
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check("out_valid_seen", BW'(out_valid), BW'(1));
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        check("scores", scores, exp);
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_valid", BW'(out_valid), BW'(1));
            check("hold_scores", scores, exp);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("valid_drop", BW'(out_valid), BW'(0));
        check("idle_busy", BW'(busy), BW'(0));
        check("scores_kept", scores, exp);
    endtask

    logic [BW-1:0] ramp_w, bias_ramp, w_max, w_min;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; bias = '0; in_valid = 1'b0;
        in_act = '0; in_w = '0; out_ready = 1'b0;
        for (int k = 0; k < N_OUT; k++) begin
            ramp_w[k*W +: W]    = 16'(256 * k);
            bias_ramp[k*W +: W] = 16'(100 * k - 500);
            w_max[k*W +: W]     = 16'h7FFF;
            w_min[k*W +: W]     = 16'h8000;
        end
        tick(); tick();
        check("rst_scores", scores, '0);
        check("rst_flags", BW'({in_ready, out_valid, busy}), BW'(0));
        rst = 1'b0;
        tick();

        // Ramp; bias changes after start must not matter.
        do_start('0);
        bias = bias_ramp;
        for (int i = 0; i < N_IN; i++) send_beat(16'd256, ramp_w, 0);
        finish_beats();
        check("ramp_s9", BW'(scores[9*W +: W]), BW'(16'd9216));
        drain(0);

        // Bias only.
        do_start(bias_ramp);
        for (int i = 0; i < N_IN; i++) send_beat(16'd0, ramp_w, 0);
        finish_beats();
        check("bias_s0", BW'(scores[0 +: W]), BW'(16'hFE0C));
        drain(0);

        // Saturation both directions.
        do_start('0);
        for (int i = 0; i < N_IN; i++) send_beat(16'h7FFF, w_max, 0);
        finish_beats();
        drain(0);
        do_start('0);
        for (int i = 0; i < N_IN; i++) send_beat(16'h7FFF, w_min, 0);
        finish_beats();
        drain(0);

        // Backpressure: gaps between beats and out_ready held low.
        do_start('0);
        for (int i = 0; i < N_IN; i++) send_beat(16'd256, ramp_w, 3);
        finish_beats();
        drain(5);

        // Ignored start during ACCUM and DONE.
        do_start('0);
        for (int i = 0; i < 2; i++) send_beat(16'd256, ramp_w, 0);
        start = 1'b1; bias = bias_ramp;
        tick();
        start = 1'b0;
        for (int i = 2; i < N_IN; i++) send_beat(16'd256, ramp_w, 0);
        finish_beats();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("done_start_busy", BW'(busy), BW'(1));
        check("done_start_valid", BW'(out_valid), BW'(1));
        drain(0);

        // Reset mid-ACCUM, then a clean ramp run.
        do_start(bias_ramp);
        for (int i = 0; i < 2; i++) send_beat(16'd256, ramp_w, 0);
        rst = 1'b1;
        #2;
        check("abort_scores", scores, '0);
        check("abort_flags", BW'({in_ready, out_valid, busy}), BW'(0));
        tick();
        rst = 1'b0;
        tick();
        do_start('0);
        for (int i = 0; i < N_IN; i++) send_beat(16'd256, ramp_w, 0);
        finish_beats();
        drain(0);

        check("sb_empty", BW'(sb_q.size()), BW'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
